// File: rtl/sdram_arb_pkg.sv
// Shared definitions for the SDRAM two-port arbiter.
// Holds the sequencer state encoding, SDRAM address field widths and the
// latched command record that is captured at grant time.
package sdram_arb_pkg;

  localparam int BANK_W = 2;
  localparam int ROW_W  = 13;
  localparam int COL_W  = 8;
  localparam int ADDR_W = BANK_W + ROW_W + COL_W;
  localparam int DATA_W = 16;
  localparam int BE_W   = 2;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WR_REQ  = 3'd1,
    WR_DATA = 3'd2,
    RD_REQ  = 3'd3,
    RD_DATA = 3'd4,
    DONE    = 3'd5
  } state_e;

  typedef struct packed {
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic [BE_W-1:0]   be;
  } cmd_t;

endpackage

// File: rtl/sdram_rr_arb2.sv
// Two-way round-robin grant logic.
// Ports:
//   clk, rst  - clock, async active-high reset
//   req_i     - request vector (bit n = port n)
//   en_i      - grant enable; no grant is issued while low
//   gnt_o     - one-hot grant, combinational, valid only while en_i
// The last-granted port is remembered; reset leaves it at port 1 so that
// port 0 wins the first contended arbitration.
module sdram_rr_arb2 (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req_i,
  input  logic       en_i,
  output logic [1:0] gnt_o
);

  logic last_q;

  always_comb begin
    gnt_o = 2'b00;
    if (en_i) begin
      case (req_i)
        2'b01:   gnt_o = 2'b01;
        2'b10:   gnt_o = 2'b10;
        2'b11:   gnt_o = last_q ? 2'b01 : 2'b10;
        default: gnt_o = 2'b00;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)          last_q <= 1'b1;
    else if (|gnt_o)  last_q <= gnt_o[1];
  end

endmodule

// File: rtl/sdram_port_arb.sv
// Two-requester round-robin arbiter and single-word transaction sequencer
// in front of the SDRAM controller top.
// Ports:
//   clk, rst                 - clock, async active-high reset
//   pN_req/we/addr/wdata/be  - requester N command (held until pN_ack)
//   pN_ack/err/rdata         - completion pulse, timeout flag, read data
//   sdram_init_done          - grants are only issued once this is high
//   sdram_wr_req/rd_req      - requests to the SDRAM top
//   sdram_wr_ack/rd_ack      - data-phase acknowledges from the SDRAM top
//   sys_wraddr/rdaddr/data_in/sdram_byteenable - latched command fields
//   sys_data_out             - read data from the SDRAM top
//   sdwr_byte/sdrd_byte      - constant transfer length
//
// state   | meaning
// IDLE    | waiting for init_done and a request; arbitrate
// WR_REQ  | write request raised, waiting for wr_ack
// WR_DATA | write data phase, waiting for wr_ack to fall
// RD_REQ  | read request raised, waiting for rd_ack
// RD_DATA | read data phase (first beat captured), waiting for rd_ack fall
// DONE    | one-cycle ack/err pulse to the owning port
module sdram_port_arb
  import sdram_arb_pkg::*;
#(
  parameter int         TIMEOUT  = 1023,
  parameter logic [8:0] XFER_LEN = 9'd1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              p0_req,
  input  logic              p0_we,
  input  logic [ADDR_W-1:0] p0_addr,
  input  logic [DATA_W-1:0] p0_wdata,
  input  logic [BE_W-1:0]   p0_be,
  output logic              p0_ack,
  output logic              p0_err,
  output logic [DATA_W-1:0] p0_rdata,
  input  logic              p1_req,
  input  logic              p1_we,
  input  logic [ADDR_W-1:0] p1_addr,
  input  logic [DATA_W-1:0] p1_wdata,
  input  logic [BE_W-1:0]   p1_be,
  output logic              p1_ack,
  output logic              p1_err,
  output logic [DATA_W-1:0] p1_rdata,
  input  logic              sdram_init_done,
  output logic              sdram_wr_req,
  output logic              sdram_rd_req,
  input  logic              sdram_wr_ack,
  input  logic              sdram_rd_ack,
  output logic [ADDR_W-1:0] sys_wraddr,
  output logic [ADDR_W-1:0] sys_rdaddr,
  output logic [DATA_W-1:0] sys_data_in,
  input  logic [DATA_W-1:0] sys_data_out,
  output logic [BE_W-1:0]   sdram_byteenable,
  output logic [8:0]        sdwr_byte,
  output logic [8:0]        sdrd_byte
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);

  state_e            state_q, state_d;
  cmd_t              cmd_q, cmd_d;
  logic              owner_q, owner_d;
  logic              err_q, err_d;
  logic [DATA_W-1:0] rd_buf_q, rd_buf_d;
  logic [DATA_W-1:0] p0_rdata_q, p0_rdata_d;
  logic [DATA_W-1:0] p1_rdata_q, p1_rdata_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [1:0]        gnt;
  logic              timeout_hit;
  logic              rd_upd;

  sdram_rr_arb2 u_arb (
    .clk   (clk),
    .rst   (rst),
    .req_i ({p1_req, p0_req}),
    .en_i  ((state_q == IDLE) && sdram_init_done),
    .gnt_o (gnt)
  );

  // Abort on the cycle the counter would reach TIMEOUT, so the SDRAM request
  // is held for exactly TIMEOUT cycles.
  assign timeout_hit = (cnt_q == CNT_W'(TIMEOUT - 1));

  always_comb begin
    state_d    = state_q;
    cmd_d      = cmd_q;
    owner_d    = owner_q;
    err_d      = err_q;
    rd_buf_d   = rd_buf_q;
    cnt_d      = cnt_q;
    rd_upd     = 1'b0;
    p0_rdata_d = p0_rdata_q;
    p1_rdata_d = p1_rdata_q;

    case (state_q)
      IDLE: begin
        if (|gnt) begin
          owner_d = gnt[1];
          cmd_d   = gnt[1] ? {p1_we, p1_addr, p1_wdata, p1_be}
                           : {p0_we, p0_addr, p0_wdata, p0_be};
          err_d   = 1'b0;
          cnt_d   = '0;
          state_d = cmd_d.we ? WR_REQ : RD_REQ;
        end
      end
      WR_REQ: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (timeout_hit)       begin err_d = 1'b1; state_d = DONE; end
        else if (sdram_wr_ack) state_d = WR_DATA;
      end
      WR_DATA: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (timeout_hit)        begin err_d = 1'b1; state_d = DONE; end
        else if (!sdram_wr_ack) state_d = DONE;
      end
      RD_REQ: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (timeout_hit) begin
          err_d   = 1'b1;
          state_d = DONE;
        end else if (sdram_rd_ack) begin
          rd_buf_d = sys_data_out;
          state_d  = RD_DATA;
        end
      end
      RD_DATA: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (timeout_hit) begin
          err_d   = 1'b1;
          state_d = DONE;
        end else if (!sdram_rd_ack) begin
          rd_upd  = 1'b1;
          state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Read data lands in the port register on the edge entering DONE so it
    // is already valid while the ack pulse is high.
    if (rd_upd && !owner_q) p0_rdata_d = rd_buf_q;
    if (rd_upd &&  owner_q) p1_rdata_d = rd_buf_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      cmd_q      <= '0;
      owner_q    <= 1'b0;
      err_q      <= 1'b0;
      rd_buf_q   <= '0;
      cnt_q      <= '0;
      p0_rdata_q <= '0;
      p1_rdata_q <= '0;
    end else begin
      state_q    <= state_d;
      cmd_q      <= cmd_d;
      owner_q    <= owner_d;
      err_q      <= err_d;
      rd_buf_q   <= rd_buf_d;
      cnt_q      <= cnt_d;
      p0_rdata_q <= p0_rdata_d;
      p1_rdata_q <= p1_rdata_d;
    end
  end

  assign sdram_wr_req     = (state_q == WR_REQ);
  assign sdram_rd_req     = (state_q == RD_REQ);
  assign sys_wraddr       = cmd_q.addr;
  assign sys_rdaddr       = cmd_q.addr;
  assign sys_data_in      = cmd_q.wdata;
  assign sdram_byteenable = cmd_q.be;
  assign sdwr_byte        = XFER_LEN;
  assign sdrd_byte        = XFER_LEN;

  assign p0_ack   = (state_q == DONE) && !owner_q;
  assign p1_ack   = (state_q == DONE) &&  owner_q;
  assign p0_err   = p0_ack && err_q;
  assign p1_err   = p1_ack && err_q;
  assign p0_rdata = p0_rdata_q;
  assign p1_rdata = p1_rdata_q;

endmodule
